// File: rtl/msm_pkg.sv
// Shared definitions for the MSM point fetch path: field widths, default window size
// and the fetch scheduler state encoding.
package msm_pkg;

    localparam int EC_BASE_FIELD_WIDTH   = 377;
    localparam int EC_SCALAR_FIELD_WIDTH = 253;
    localparam int DEFAULT_WINDOW_BITS   = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/msm_digit_extract.sv
// Pippenger window digit: scalar[window_idx*WINDOW_BITS +: WINDOW_BITS], with bits past
// the top of the scalar reading as zero.
module msm_digit_extract #(
    parameter int SCALAR_WIDTH = msm_pkg::EC_SCALAR_FIELD_WIDTH,
    parameter int WINDOW_BITS  = msm_pkg::DEFAULT_WINDOW_BITS
) (
    input  logic [SCALAR_WIDTH-1:0] scalar,
    input  logic [7:0]              window_idx,
    output logic [WINDOW_BITS-1:0]  digit
);

    logic [15:0]             bit_base;
    logic [SCALAR_WIDTH-1:0] shifted;

    // A logical right shift fills with zeros, which gives the zero-fill for windows
    // that straddle or lie beyond the scalar's top bit.
    assign bit_base = 16'(window_idx) * 16'(WINDOW_BITS);
    assign shifted  = scalar >> bit_base;
    assign digit    = shifted[WINDOW_BITS-1:0];

endmodule

// File: rtl/msm_point_fetch_scheduler.sv
// Walks the point/scalar memories for one Pippenger window and streams (point, bucket)
// pairs downstream. Define SKIP_ZERO_DIGIT_EN to drop zero-digit points and count them.
//
// state      | meaning
// ST_IDLE    | waiting for ap_start, ap_idle high
// ST_READ    | address idx presented, ce0 high
// ST_CAPTURE | memory data registered, digit computed
// ST_EMIT    | out_valid high until out_ready
// ST_DONE    | one-cycle ap_done pulse
module msm_point_fetch_scheduler #(
    parameter int EC_BASE_FIELD_WIDTH   = msm_pkg::EC_BASE_FIELD_WIDTH,
    parameter int EC_SCALAR_FIELD_WIDTH = msm_pkg::EC_SCALAR_FIELD_WIDTH,
    parameter int ADDR_WIDTH            = 4,
    parameter int WINDOW_BITS           = msm_pkg::DEFAULT_WINDOW_BITS
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic                             ap_start,
    input  logic [7:0]                       window_idx,
    input  logic [ADDR_WIDTH:0]              num_points,
    output logic                             ap_idle,
    output logic                             ap_done,
    output logic [ADDR_WIDTH-1:0]            P_arr_V_address0,
    output logic                             P_arr_V_ce0,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_x_V_q0,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_y_V_q0,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_z_V_q0,
    input  logic [EC_SCALAR_FIELD_WIDTH-1:0] K_arr_V_q0,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   out_x,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   out_y,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   out_z,
    output logic [WINDOW_BITS-1:0]           out_bucket,
    output logic                             out_last,
    output logic [ADDR_WIDTH:0]              skip_count
);

    import msm_pkg::*;

    fetch_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [ADDR_WIDTH:0]     num_pts_r;
    logic [7:0]              win_r;
    logic [WINDOW_BITS-1:0]  digit;
    logic                    at_last;
    logic                    skip_now;
    logic                    advance;
    logic                    start_walk;

    msm_digit_extract #(
        .SCALAR_WIDTH (EC_SCALAR_FIELD_WIDTH),
        .WINDOW_BITS  (WINDOW_BITS)
    ) u_digit (
        .scalar     (K_arr_V_q0),
        .window_idx (win_r),
        .digit      (digit)
    );

    assign start_walk = (state == ST_IDLE) && ap_start;
    assign at_last    = ({1'b0, idx} == (num_pts_r - {{ADDR_WIDTH{1'b0}}, 1'b1}));

`ifdef SKIP_ZERO_DIGIT_EN
    assign skip_now = (state == ST_CAPTURE) && (digit == '0);
`else
    assign skip_now = 1'b0;
`endif

    assign advance = skip_now || ((state == ST_EMIT) && out_ready);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ap_start) begin
                    state_nxt = (num_points == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ:    state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                if (skip_now) begin
                    state_nxt = at_last ? ST_DONE : ST_READ;
                end else begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    state_nxt = at_last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            idx        <= '0;
            num_pts_r  <= '0;
            win_r      <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_z      <= '0;
            out_bucket <= '0;
        end else begin
            if (start_walk) begin
                win_r     <= window_idx;
                num_pts_r <= num_points;
                idx       <= '0;
            end else if (advance && !at_last) begin
                idx <= idx + 1'b1;
            end
            // Output registers only load in CAPTURE, so they stay frozen through EMIT.
            if (state == ST_CAPTURE) begin
                out_x      <= P_arr_x_V_q0;
                out_y      <= P_arr_y_V_q0;
                out_z      <= P_arr_z_V_q0;
                out_bucket <= digit;
            end
        end
    end

`ifdef SKIP_ZERO_DIGIT_EN
    logic [ADDR_WIDTH:0] skip_cnt;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            skip_cnt <= '0;
        end else if (start_walk) begin
            skip_cnt <= '0;
        end else if (skip_now) begin
            skip_cnt <= skip_cnt + 1'b1;
        end
    end

    assign skip_count = skip_cnt;
`else
    assign skip_count = '0;
`endif

    assign ap_idle          = (state == ST_IDLE);
    assign ap_done          = (state == ST_DONE);
    assign P_arr_V_ce0      = (state == ST_READ);
    assign P_arr_V_address0 = idx;
    assign out_valid        = (state == ST_EMIT);
    assign out_last         = (state == ST_EMIT) && at_last;

endmodule
